text_console: RTL and testbench

Character-stream front end that sits directly upstream of `graphics_card` in ASCII mode. It accepts bytes from the CPU over a valid/ready handshake and keeps a cursor. It turns printable characters and a small set of control codes into single-port writes to the card's character RAM. It also exports the cursor address so the card can draw the cursor.

---
 rtl/text_console_if.sv | 27 ++
 rtl/text_console.sv | 156 +++++++++++++++
 tb/tb_text_console.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/text_console_if.sv
// text_console_if: byte stream from the CPU plus the character RAM write port
// and cursor address going to graphics_card.
//   char_data/char_valid/char_ready : CPU byte handshake
//   vram_we/vram_addr/vram_data     : single-port character RAM write
//   cursor_addr                     : current cursor, row*COLS + col
// Modports: master = CPU/consumer side, slave = text_console.
interface text_console_if #(
  parameter int unsigned ADDR_W = 12
) ();
  logic [7:0]        char_data;
  logic              char_valid;
  logic              char_ready;
  logic              vram_we;
  logic [ADDR_W-1:0] vram_addr;
  logic [7:0]        vram_data;
  logic [ADDR_W-1:0] cursor_addr;

  modport master (
    output char_data, char_valid,
    input  char_ready, vram_we, vram_addr, vram_data, cursor_addr
  );

  modport slave (
    input  char_data, char_valid,
    output char_ready, vram_we, vram_addr, vram_data, cursor_addr
  );
endinterface

// File: rtl/text_console.sv
// text_console: character-stream front end for graphics_card in ASCII mode.
// Accepts bytes over a valid/ready handshake, keeps a (row, col) cursor and
// turns printable characters and LF/CR/BS/FF into character RAM writes.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : text_console_if.slave (byte handshake, RAM write port, cursor)
// Optional feature: define TEXT_CONSOLE_ROW_CLEAR_EN to blank each new row
// on every row advance (LF or line wrap).
module text_console #(
  parameter int unsigned COLS   = 80,
  parameter int unsigned ROWS   = 30,
  parameter int unsigned ADDR_W = $clog2(COLS * ROWS)
) (
  input logic           clk,
  input logic           rst,
  text_console_if.slave bus
);

  localparam int unsigned Total = COLS * ROWS;
  localparam int unsigned ColW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RowW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  // One extra count value marks the idle cycle after the last clear write.
  localparam int unsigned CntW  = $clog2(Total + 1);

  typedef enum logic [1:0] {
    StClearAll,
    StIdle
`ifdef TEXT_CONSOLE_ROW_CLEAR_EN
    , StClearRow
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [RowW-1:0]   row_q, row_d, row_next;
  logic [ColW-1:0]   col_q, col_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic [ADDR_W-1:0] cur_addr;
  logic              row_adv;
  logic [7:0]        b;

  assign b        = bus.char_data;
  assign cur_addr = ADDR_W'(32'(row_q) * COLS + 32'(col_q));
  assign row_next = (row_q == RowW'(ROWS - 1)) ? '0 : row_q + RowW'(1);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    row_adv = 1'b0;

    unique case (state_q)
      StClearAll: begin
        if (cnt_q == CntW'(Total)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          we_d   = 1'b1;
          addr_d = ADDR_W'(cnt_q);
          data_d = 8'h20;
          cnt_d  = cnt_q + CntW'(1);
        end
      end
`ifdef TEXT_CONSOLE_ROW_CLEAR_EN
      StClearRow: begin
        // row_q already holds the new row.
        if (cnt_q == CntW'(COLS)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          we_d   = 1'b1;
          addr_d = ADDR_W'(32'(row_q) * COLS + 32'(cnt_q));
          data_d = 8'h20;
          cnt_d  = cnt_q + CntW'(1);
        end
      end
`endif
      StIdle: begin
        if (bus.char_valid) begin
          if (b inside {[8'h20:8'h7E]}) begin
            we_d   = 1'b1;
            addr_d = cur_addr;
            data_d = b;
            if (col_q == ColW'(COLS - 1)) row_adv = 1'b1;
            else                          col_d   = col_q + ColW'(1);
          end else begin
            case (b)
              8'h0A: row_adv = 1'b1;
              8'h0D: col_d   = '0;
              8'h08: begin
                // BS stays on the current row; no-op at column 0.
                if (col_q != '0) begin
                  col_d  = col_q - ColW'(1);
                  we_d   = 1'b1;
                  addr_d = cur_addr - ADDR_W'(1);
                  data_d = 8'h20;
                end
              end
              8'h0C: begin
                row_d   = '0;
                col_d   = '0;
                cnt_d   = '0;
                state_d = StClearAll;
              end
              default: ;
            endcase
          end
        end
      end
      default: state_d = StClearAll;
    endcase

    if (row_adv) begin
      row_d = row_next;
      col_d = '0;
`ifdef TEXT_CONSOLE_ROW_CLEAR_EN
      cnt_d   = '0;
      state_d = StClearRow;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StClearAll;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign bus.char_ready  = (state_q == StIdle);
  assign bus.vram_we     = we_q;
  assign bus.vram_addr   = addr_q;
  assign bus.vram_data   = data_q;
  assign bus.cursor_addr = cur_addr;

endmodule

// File: tb/tb_text_console.sv
module tb_text_console;

  localparam int Cols  = 80;
  localparam int Rows  = 30;
  localparam int Total = Cols * Rows;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  text_console_if #(.ADDR_W(12)) bus ();

  text_console #(
    .COLS  (80),
    .ROWS  (30),
    .ADDR_W(12)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver only: waits (bounded) for ready, presents one byte for one edge,
  // returns at the negedge of the cycle after acceptance.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    while (bus.char_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      total++;
      bad++;
      $display("FAIL send_timeout byte=%h ready never rose", b);
    end
    bus.char_data  = b;
    bus.char_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.char_valid = 1'b0;
  endtask

  task automatic test_reset;
    int err;
    rst = 1'b0;
    bus.char_valid = 1'b0;
    bus.char_data  = 8'h00;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.char_ready, bus.vram_we} !== 2'b00) begin
      bad++;
      $display("FAIL rst_ctl ready=%b we=%b expected 0 0", bus.char_ready, bus.vram_we);
    end
    total++;
    if (bus.vram_addr !== 12'd0 || bus.cursor_addr !== 12'd0) begin
      bad++;
      $display("FAIL rst_addr addr=%0d cursor=%0d expected 0 0", bus.vram_addr,
               bus.cursor_addr);
    end
    total++;
    if (bus.vram_data !== 8'h00) begin
      bad++;
      $display("FAIL rst_data got=%h expected 00", bus.vram_data);
    end
    rst = 1'b1;
    err = 0;
    for (int i = 0; i < Total; i++) begin
      @(negedge clk);
      if (bus.vram_we !== 1'b1 || bus.vram_addr !== 12'(i) || bus.vram_data !== 8'h20 ||
          bus.char_ready !== 1'b0) begin
        if (err == 0)
          $display("FAIL rst_clear idx=%0d we=%b addr=%0d data=%h ready=%b expected 1 %0d 20 0",
                   i, bus.vram_we, bus.vram_addr, bus.vram_data, bus.char_ready, i);
        err++;
      end
    end
    total++;
    if (err != 0) bad++;
    @(negedge clk);
    total++;
    if (bus.char_ready !== 1'b1 || bus.vram_we !== 1'b0 || bus.cursor_addr !== 12'd0) begin
      bad++;
      $display("FAIL rst_done ready=%b we=%b cursor=%0d expected 1 0 0", bus.char_ready,
               bus.vram_we, bus.cursor_addr);
    end
  endtask

  task automatic test_single_char;
    send_byte(8'h41);
    total++;
    if (bus.vram_we !== 1'b1 || bus.vram_addr !== 12'd0 || bus.vram_data !== 8'h41) begin
      bad++;
      $display("FAIL char_write we=%b addr=%0d data=%h expected 1 0 41", bus.vram_we,
               bus.vram_addr, bus.vram_data);
    end
    total++;
    if (bus.cursor_addr !== 12'd1 || bus.char_ready !== 1'b1) begin
      bad++;
      $display("FAIL char_cursor cursor=%0d ready=%b expected 1 1", bus.cursor_addr,
               bus.char_ready);
    end
  endtask

  task automatic test_controls;
    logic [7:0] nop_b [5];
    nop_b = '{8'h08, 8'h0D, 8'h07, 8'h7F, 8'hC3};
    send_byte(8'h0D);
    total++;
    if (bus.vram_we !== 1'b0 || bus.cursor_addr !== 12'd0) begin
      bad++;
      $display("FAIL cr we=%b cursor=%0d expected 0 0", bus.vram_we, bus.cursor_addr);
    end
    send_byte(8'h41);
    total++;
    if (bus.vram_we !== 1'b1 || bus.vram_addr !== 12'd0 || bus.cursor_addr !== 12'd1) begin
      bad++;
      $display("FAIL ctl_char we=%b addr=%0d cursor=%0d expected 1 0 1", bus.vram_we,
               bus.vram_addr, bus.cursor_addr);
    end
    send_byte(8'h08);
    total++;
    if (bus.vram_we !== 1'b1 || bus.vram_addr !== 12'd0 || bus.vram_data !== 8'h20 ||
        bus.cursor_addr !== 12'd0) begin
      bad++;
      $display("FAIL bs_write we=%b addr=%0d data=%h cursor=%0d expected 1 0 20 0",
               bus.vram_we, bus.vram_addr, bus.vram_data, bus.cursor_addr);
    end
    for (int i = 0; i < 5; i++) begin
      send_byte(nop_b[i]);
      total++;
      if (bus.vram_we !== 1'b0 || bus.cursor_addr !== 12'd0) begin
        bad++;
        $display("FAIL nop_%h we=%b cursor=%0d expected 0 0", nop_b[i], bus.vram_we,
                 bus.cursor_addr);
      end
    end
  endtask

  task automatic test_screen_wrap;
    int err_we;
    int err_cur;
    int err;
    err_we  = 0;
    err_cur = 0;
    for (int k = 0; k < Rows; k++) begin
      send_byte(8'h0A);
      if (bus.vram_we !== 1'b0) err_we++;
      if (bus.cursor_addr !== 12'(((k + 1) % Rows) * Cols)) begin
        if (err_cur == 0)
          $display("FAIL lf_cursor lf=%0d cursor=%0d expected %0d", k + 1, bus.cursor_addr,
                   ((k + 1) % Rows) * Cols);
        err_cur++;
      end
    end
    total++;
    if (err_cur != 0) bad++;
    total++;
    if (err_we != 0) begin
      bad++;
      $display("FAIL lf_nowrite count=%0d expected 0", err_we);
    end
`ifdef TEXT_CONSOLE_ROW_CLEAR_EN
    err = 0;
    for (int i = 0; i < Cols; i++) begin
      @(negedge clk);
      if (bus.vram_we !== 1'b1 || bus.vram_addr !== 12'(i) || bus.vram_data !== 8'h20) begin
        if (err == 0)
          $display("FAIL row0_clear idx=%0d we=%b addr=%0d data=%h expected 1 %0d 20",
                   i, bus.vram_we, bus.vram_addr, bus.vram_data, i);
        err++;
      end
    end
    total++;
    if (err != 0) bad++;
    @(negedge clk);
`else
    err = 0;
`endif
    total++;
    if (bus.char_ready !== 1'b1 || bus.cursor_addr !== 12'd0) begin
      bad++;
      $display("FAIL wrap_done ready=%b cursor=%0d expected 1 0", bus.char_ready,
               bus.cursor_addr);
    end
  endtask

  // 80 bytes on a held char_valid: also the back-to-back case.
  task automatic test_line_wrap;
    int err;
    int exp_cur;
    logic exp_rdy;
    err = 0;
    bus.char_data  = 8'h42;
    bus.char_valid = 1'b1;
    for (int i = 0; i < Cols; i++) begin
      @(posedge clk);
      @(negedge clk);
      exp_cur = (i < Cols - 1) ? i + 1 : Cols;
`ifdef TEXT_CONSOLE_ROW_CLEAR_EN
      exp_rdy = (i < Cols - 1);
`else
      exp_rdy = 1'b1;
`endif
      if (bus.vram_we !== 1'b1 || bus.vram_addr !== 12'(i) || bus.vram_data !== 8'h42 ||
          bus.cursor_addr !== 12'(exp_cur) || bus.char_ready !== exp_rdy) begin
        if (err == 0)
          $display("FAIL b2b_char idx=%0d we=%b addr=%0d data=%h cur=%0d rdy=%b exp 1 %0d 42 %0d %b",
                   i, bus.vram_we, bus.vram_addr, bus.vram_data, bus.cursor_addr,
                   bus.char_ready, i, exp_cur, exp_rdy);
        err++;
      end
    end
    bus.char_valid = 1'b0;
    total++;
    if (err != 0) bad++;
`ifdef TEXT_CONSOLE_ROW_CLEAR_EN
    err = 0;
    for (int i = 0; i < Cols; i++) begin
      @(negedge clk);
      if (bus.vram_we !== 1'b1 || bus.vram_addr !== 12'(Cols + i) ||
          bus.vram_data !== 8'h20 || bus.char_ready !== 1'b0) begin
        if (err == 0)
          $display("FAIL row1_clear idx=%0d we=%b addr=%0d data=%h rdy=%b exp 1 %0d 20 0",
                   i, bus.vram_we, bus.vram_addr, bus.vram_data, bus.char_ready, Cols + i);
        err++;
      end
    end
    total++;
    if (err != 0) bad++;
    @(negedge clk);
    total++;
    if (bus.char_ready !== 1'b1 || bus.vram_we !== 1'b0) begin
      bad++;
      $display("FAIL row1_done ready=%b we=%b expected 1 0", bus.char_ready, bus.vram_we);
    end
`endif
    total++;
    if (bus.cursor_addr !== 12'd80) begin
      bad++;
      $display("FAIL wrap_cursor got=%0d expected 80", bus.cursor_addr);
    end
  endtask

  task automatic test_ff_reset_mid_clear;
    int err;
    send_byte(8'h0C);
    total++;
    if (bus.vram_we !== 1'b0 || bus.char_ready !== 1'b0 || bus.cursor_addr !== 12'd0) begin
      bad++;
      $display("FAIL ff_first we=%b ready=%b cursor=%0d expected 0 0 0", bus.vram_we,
               bus.char_ready, bus.cursor_addr);
    end
    err = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.vram_we !== 1'b1 || bus.vram_addr !== 12'(i) || bus.vram_data !== 8'h20) begin
        if (err == 0)
          $display("FAIL ff_clear idx=%0d we=%b addr=%0d data=%h expected 1 %0d 20",
                   i, bus.vram_we, bus.vram_addr, bus.vram_data, i);
        err++;
      end
    end
    total++;
    if (err != 0) bad++;
    #2 rst = 1'b0;
    #1;
    total++;
    if (bus.vram_we !== 1'b0 || bus.vram_addr !== 12'd0 || bus.vram_data !== 8'h00 ||
        bus.char_ready !== 1'b0 || bus.cursor_addr !== 12'd0) begin
      bad++;
      $display("FAIL mid_rst we=%b addr=%0d data=%h ready=%b cursor=%0d expected 0 0 00 0 0",
               bus.vram_we, bus.vram_addr, bus.vram_data, bus.char_ready, bus.cursor_addr);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    err = 0;
    for (int i = 0; i < Total; i++) begin
      @(negedge clk);
      if (bus.vram_we !== 1'b1 || bus.vram_addr !== 12'(i) || bus.vram_data !== 8'h20) begin
        if (err == 0)
          $display("FAIL reclear idx=%0d we=%b addr=%0d data=%h expected 1 %0d 20",
                   i, bus.vram_we, bus.vram_addr, bus.vram_data, i);
        err++;
      end
    end
    total++;
    if (err != 0) bad++;
    @(negedge clk);
    total++;
    if (bus.char_ready !== 1'b1 || bus.vram_we !== 1'b0 || bus.cursor_addr !== 12'd0) begin
      bad++;
      $display("FAIL reclear_done ready=%b we=%b cursor=%0d expected 1 0 0", bus.char_ready,
               bus.vram_we, bus.cursor_addr);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_char();
    test_controls();
    test_screen_wrap();
    test_line_wrap();
    test_ff_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
